// File: rtl/sample_stream_player.sv
// Sample-memory playback engine: sequences read addresses into a synchronous sample RAM,
// streams the returned words, and emits a decimated capture strobe with a capture address.
module sample_stream_player #(
    parameter int SAMPLE_W = 1,
    parameter int NUM_CH   = 1,
    parameter int ADDR_W   = 22,
    parameter int DECIM    = 10000,
    parameter int CAP_W    = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic [ADDR_W-1:0]          length,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd_en,
    input  logic [NUM_CH*SAMPLE_W-1:0] mem_data,
    output logic [NUM_CH*SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       cap_stb,
    output logic [CAP_W-1:0]           cap_addr,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 wrap_cnt
);

    localparam int WORD_W = NUM_CH * SAMPLE_W;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   addr_d;
    logic                rd_en_d;
    logic [7:0]          wrap_d;
    logic                drain_q, drain_d;
    logic                done_d;
    logic                accept;

    logic                vld_p0, vld_p1;
    logic [WORD_W-1:0]   smp_p1;
    logic                cap_stb_p1;
    logic [DCNT_W-1:0]   dec_cnt;
    logic [CAP_W-1:0]    cap_addr_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = mem_addr;
        rd_en_d = mem_rd_en;
        wrap_d  = wrap_cnt;
        drain_d = drain_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop && (length != '0)) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    addr_d  = '0;
                    rd_en_d = 1'b1;
                    wrap_d  = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    rd_en_d = 1'b0;
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else if (mem_addr == len_q - 1'b1) begin
                    // loop_en is sampled live at every wrap point
                    if (loop_en) begin
                        addr_d = '0;
                        wrap_d = sat_inc8(wrap_cnt);
                    end else begin
                        rd_en_d = 1'b0;
                        drain_d = 1'b0;
                        state_d = DRAIN;
                    end
                end else begin
                    addr_d = mem_addr + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            len_q     <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            wrap_cnt  <= '0;
            drain_q   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_addr  <= addr_d;
            mem_rd_en <= rd_en_d;
            wrap_cnt  <= wrap_d;
            drain_q   <= drain_d;
            done      <= done_d;
            if (accept) len_q <= length;
        end
    end

    // p0: RAM read data returns; p1: registered sample, valid and capture strobe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            smp_p1     <= '0;
            cap_stb_p1 <= 1'b0;
            dec_cnt    <= '0;
            cap_addr_q <= '0;
        end else begin
            vld_p0     <= mem_rd_en;
            vld_p1     <= vld_p0;
            cap_stb_p1 <= 1'b0;
            if (vld_p0) smp_p1 <= mem_data;
            if (accept) begin
                dec_cnt    <= '0;
                cap_addr_q <= '0;
            end else begin
                if (vld_p0) begin
                    if (dec_cnt == DCNT_LAST) begin
                        dec_cnt    <= '0;
                        cap_stb_p1 <= 1'b1;
                    end else begin
                        dec_cnt <= dec_cnt + 1'b1;
                    end
                end
                if (cap_stb_p1) cap_addr_q <= cap_addr_q + 1'b1;
            end
        end
    end

    assign sample_out   = smp_p1;
    assign sample_valid = vld_p1;
    assign cap_stb      = cap_stb_p1;
    assign cap_addr     = cap_addr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sample_stream_player.sv
// Directed bench for sample_stream_player: two instances (2x4-bit words with DECIM=2, and
// 4x3-bit words with DECIM=1) share control; a scoreboard checks addresses and samples.
`timescale 1ns/1ps
module tb_sample_stream_player;

    localparam int AW = 10;
    localparam int WA = 8;
    localparam int WB = 12;

    logic CLK = 1'b0;
    logic RST, start, stop, loop_en;
    logic [AW-1:0] length;

    logic [AW-1:0] addr_a, addr_b;
    logic          rd_a, rd_b;
    logic [WA-1:0] data_a, smp_a;
    logic [WB-1:0] data_b, smp_b;
    logic          sv_a, sv_b, cs_a, cs_b, busy_a, busy_b, done_a, done_b;
    logic [3:0]    ca_a;
    logic [15:0]   ca_b;
    logic [7:0]    wc_a, wc_b;

    sample_stream_player #(.SAMPLE_W(4), .NUM_CH(2), .ADDR_W(AW), .DECIM(2), .CAP_W(4)) dut_a (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .loop_en(loop_en), .length(length),
        .mem_addr(addr_a), .mem_rd_en(rd_a), .mem_data(data_a), .sample_out(smp_a),
        .sample_valid(sv_a), .cap_stb(cs_a), .cap_addr(ca_a), .busy(busy_a), .done(done_a),
        .wrap_cnt(wc_a));

    sample_stream_player #(.SAMPLE_W(3), .NUM_CH(4), .ADDR_W(AW), .DECIM(1), .CAP_W(16)) dut_b (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .loop_en(loop_en), .length(length),
        .mem_addr(addr_b), .mem_rd_en(rd_b), .mem_data(data_b), .sample_out(smp_b),
        .sample_valid(sv_b), .cap_stb(cs_b), .cap_addr(ca_b), .busy(busy_b), .done(done_b),
        .wrap_cnt(wc_b));

    always #5 CLK = ~CLK;

    typedef struct {int addr; bit cap;} exp_t;
    int   q_rd[$];
    exp_t q_a[$];
    int   q_b[$];
    int   errors = 0, checks = 0;
    int   done_a_cnt = 0, sc_a = 0;

    function automatic logic [WA-1:0] ram_a(input int a);
        int v;
        v = a * 37 + 11;
        return WA'(v);
    endfunction

    function automatic logic [WB-1:0] ram_b(input int a);
        int v;
        v = (a * 291) ^ 32'hA5C;
        return WB'(v);
    endfunction

    // Synchronous sample RAMs: data valid the cycle after the read strobe
    always @(posedge CLK) begin
        if (rd_a) data_a <= ram_a(int'(addr_a));
        if (rd_b) data_b <= ram_b(int'(addr_b));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (rd_a) begin
                chk("rd_pending", 64'(q_rd.size() > 0), 64'd1);
                if (q_rd.size() > 0) chk("mem_addr", 64'(addr_a), 64'(q_rd.pop_front()));
            end
            if (sv_a) begin
                chk("a_pending", 64'(q_a.size() > 0), 64'd1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    chk("a_sample", 64'(smp_a), 64'(ram_a(e.addr)));
                    chk("a_cap_stb", 64'(cs_a), 64'(e.cap));
                end
            end else begin
                chk("a_cap_idle", 64'(cs_a), 64'd0);
            end
            if (sv_b) begin
                chk("b_pending", 64'(q_b.size() > 0), 64'd1);
                if (q_b.size() > 0) chk("b_sample", 64'(smp_b), 64'(ram_b(q_b.pop_front())));
            end
            chk("b_cap_eq_valid", 64'(cs_b), 64'(sv_b));
            if (done_a) done_a_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_seq(input int n, input int len);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            q_rd.push_back(i % len);
            sc_a++;
            e.addr = i % len;
            e.cap  = (sc_a % 2 == 0);
            q_a.push_back(e);
            q_b.push_back(i % len);
        end
    endtask

    task automatic start_pulse(input int len);
        length = AW'(len);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int from, input int budget, output int cyc);
        cyc = from;
        while (!done_a && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_end(input string tag, input int cyc, input int exp_cyc,
                             input int cap_a, input int cap_b, input int wc);
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_done"}, 64'(done_a), 64'd1);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_b_done"}, 64'(done_b), 64'd1);
        chk({tag, "_b_busy"}, 64'(busy_b), 64'd0);
        chk({tag, "_cap_addr_a"}, 64'(ca_a), 64'(cap_a));
        chk({tag, "_cap_addr_b"}, 64'(ca_b), 64'(cap_b));
        chk({tag, "_wrap_cnt"}, 64'(wc_a), 64'(wc));
        chk({tag, "_wrap_cnt_b"}, 64'(wc_b), 64'(wc));
        chk({tag, "_reads_left"}, 64'(q_rd.size()), 64'd0);
        chk({tag, "_samples_left"}, 64'(q_a.size() + q_b.size()), 64'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, 64'(addr_a), 64'd0);
        chk({tag, "_rd"}, 64'(rd_a), 64'd0);
        chk({tag, "_smp"}, 64'(smp_a), 64'd0);
        chk({tag, "_sv"}, 64'(sv_a), 64'd0);
        chk({tag, "_cs"}, 64'(cs_a), 64'd0);
        chk({tag, "_ca"}, 64'(ca_a), 64'd0);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_done"}, 64'(done_a), 64'd0);
        chk({tag, "_wc"}, 64'(wc_a), 64'd0);
        chk({tag, "_b_addr"}, 64'(addr_b), 64'd0);
        chk({tag, "_b_rd"}, 64'(rd_b), 64'd0);
        chk({tag, "_b_smp"}, 64'(smp_b), 64'd0);
        chk({tag, "_b_sv"}, 64'(sv_b), 64'd0);
        chk({tag, "_b_ca"}, 64'(ca_b), 64'd0);
        chk({tag, "_b_busy"}, 64'(busy_b), 64'd0);
        chk({tag, "_b_wc"}, 64'(wc_b), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc, d;
        RST = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; length = '0;
        tick();
        tick();
        chk_reset("reset");
        RST = 1'b0;
        tick();

        // One-shot, length 5
        sc_a = 0;
        d = done_a_cnt;
        push_seq(5, 5);
        start_pulse(5);
        chk("os_rd_c1", 64'(rd_a), 64'd1);
        chk("os_addr_c1", 64'(addr_a), 64'd0);
        chk("os_sv_c1", 64'(sv_a), 64'd0);
        tick();
        chk("os_sv_c2", 64'(sv_a), 64'd0);
        tick();
        chk("os_sv_c3", 64'(sv_a), 64'd1);
        wait_done(3, 40, cyc);
        check_end("oneshot", cyc, 8, 2, 5, 0);
        repeat (3) tick();
        chk("os_done_once", 64'(done_a_cnt - d), 64'd1);
        chk("os_done_low", 64'(done_a), 64'd0);

        // Loop, length 3, loop_en dropped during the 10th read
        sc_a = 0;
        loop_en = 1'b1;
        push_seq(12, 3);
        start_pulse(3);
        repeat (9) tick();
        loop_en = 1'b0;
        wait_done(10, 60, cyc);
        check_end("loop", cyc, 15, 6, 12, 3);
        tick();

        // Abort on the 4th RUN cycle of length 100
        sc_a = 0;
        push_seq(4, 100);
        start_pulse(100);
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_rd_drop", 64'(rd_a), 64'd0);
        chk("abort_busy", 64'(busy_a), 64'd1);
        wait_done(5, 40, cyc);
        check_end("abort", cyc, 7, 2, 4, 0);
        tick();

        // Corner starts
        d = done_a_cnt;
        start_pulse(0);
        chk("len0_busy", 64'(busy_a), 64'd0);
        tick();
        tick();
        chk("len0_busy_later", 64'(busy_a), 64'd0);
        length = AW'(5);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", 64'(busy_a), 64'd0);
        tick();
        chk("startstop_rd", 64'(rd_a), 64'd0);
        chk("corner_no_done", 64'(done_a_cnt - d), 64'd0);

        sc_a = 0;
        push_seq(6, 6);
        start_pulse(6);
        tick();
        length = AW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(3, 40, cyc);
        check_end("restart_ignored", cyc, 9, 3, 6, 0);
        tick();

        // Reset at address 50, then a fresh playback
        sc_a = 0;
        push_seq(100, 100);
        start_pulse(100);
        repeat (50) tick();
        chk("rst_pre_addr", 64'(addr_a), 64'd50);
        d = done_a_cnt;
        RST = 1'b1;
        #1;
        chk_reset("midrst");
        q_rd.delete();
        q_a.delete();
        q_b.delete();
        tick();
        tick();
        RST = 1'b0;
        repeat (5) tick();
        chk("midrst_no_done", 64'(done_a_cnt - d), 64'd0);
        chk("midrst_idle", 64'(busy_a), 64'd0);
        sc_a = 0;
        push_seq(4, 4);
        start_pulse(4);
        chk("replay_addr", 64'(addr_a), 64'd0);
        chk("replay_cap_addr", 64'(ca_a), 64'd0);
        wait_done(1, 40, cyc);
        check_end("replay", cyc, 7, 2, 4, 0);
        tick();

        // wrap_cnt saturation: length 1 looping for 300 reads
        sc_a = 0;
        loop_en = 1'b1;
        push_seq(300, 1);
        start_pulse(1);
        repeat (199) tick();
        chk("sat_wrap_199", 64'(wc_a), 64'd199);
        repeat (100) tick();
        loop_en = 1'b0;
        wait_done(300, 400, cyc);
        check_end("saturate", cyc, 303, 6, 300, 255);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_stream_player.md
# sample_stream_player

Parametrised sample-memory playback and capture-strobe engine for the GPS front-end. It sequences addresses into a synchronous sample RAM and streams NUM_CH channels of SAMPLE_W-bit samples into the receiver chain. It supports one-shot and looped playback, abort, and a decimated capture strobe with a capture address for the output-logging RAM. It replaces the fixed free-running address counter and the separate 10 kHz prescaler used for playback/capture today.

## Interface
- SAMPLE_W, 1: bits per sample per channel
- NUM_CH, 1: channels packed in one memory word, channel 0 in the LSBs
- ADDR_W, 22: sample-memory address width
- DECIM, 10000: valid samples per capture strobe, ≥1
- CAP_W, 16: capture address width

- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- start  in  1  begin playback, honoured only in IDLE
- stop  in  1  abort playback
- loop_en  in  1  wrap to address 0 after the last sample instead of finishing
- length  in  ADDR_W  number of samples, latched on accepted start
- mem_addr  out  ADDR_W  sample RAM read address
- mem_rd_en  out  1  read strobe to sample RAM
- mem_data  in  NUM_CH*SAMPLE_W  RAM read data, valid 1 cycle after mem_rd_en
- sample_out  out  NUM_CH*SAMPLE_W  registered sample
- sample_valid  out  1  sample_out holds a new sample this cycle
- cap_stb  out  1  one-cycle pulse on every DECIM-th valid sample
- cap_addr  out  CAP_W  capture RAM address, advances after each cap_stb
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when playback completes or aborts
- wrap_cnt  out  8  completed loops, saturates at 255

## Operation
- States: IDLE, RUN, DRAIN.
- In IDLE, start=1 with length≠0 and stop=0 is accepted:
  - latch length;
  - clear mem_addr, wrap_cnt, the decimation counter and cap_addr;
  - go to RUN.
- start with length=0 is ignored.
- start and stop together in IDLE: stop wins and start is ignored.
- RUN behaviour:
  - mem_rd_en=1 every cycle; mem_addr increments by 1 per cycle.
  - At mem_addr=length−1 with loop_en=1: next mem_addr=0 and wrap_cnt+1 (saturating). loop_en is sampled live at each wrap.
  - At mem_addr=length−1 with loop_en=0: go to DRAIN.
- stop=1 in RUN: mem_rd_en drops the next cycle and the state goes to DRAIN. No new reads are issued; reads already in flight still produce samples.
- DRAIN: lasts 2 cycles to flush the read pipeline. Then done pulses for 1 cycle and the state returns to IDLE. stop in DRAIN has no additional effect.
- start in RUN or DRAIN is ignored.
- Sample path: sample_out registers mem_data; sample_valid is mem_rd_en delayed by 2 cycles.
- Decimation counter:
  - counts sample_valid cycles from 0 to DECIM−1;
  - cap_stb is asserted in the same cycle as the sample_valid that hits DECIM−1, after which the counter returns to 0;
  - cap_addr increments on the cycle after cap_stb and wraps modulo 2^CAP_W.
- DECIM=1: cap_stb equals sample_valid.
- The decimation counter and cap_addr persist across loop wraps and are cleared only by an accepted start or by RST.

## Timing
- Reset values: mem_addr=0, mem_rd_en=0, sample_out=0, sample_valid=0, cap_stb=0, cap_addr=0, busy=0, done=0, wrap_cnt=0, state IDLE.
- start accepted at edge k: mem_rd_en=1 and mem_addr=0 from cycle k+1. The first sample_valid is at cycle k+3.
- Latency from mem_rd_en to sample_valid: 2 cycles, fixed. Throughput is 1 sample per cycle in RUN.
- One-shot of length L:
  - mem_rd_en high for L cycles;
  - sample_valid high for L consecutive cycles;
  - done pulses in the cycle after the last sample_valid;
  - busy falls together with done.
- Loop wrap: no bubble. Address length−1 is followed immediately by address 0.
- RST asserted mid-operation: all outputs return to reset values asynchronously. No done pulse is produced.

## Test plan
- One-shot: length=5, DECIM=2, loop_en=0, start pulse.
  - mem_addr 0..4 on consecutive cycles.
  - sample_valid carries RAM words 0..4 two cycles after each read.
  - cap_stb on the 2nd and 4th samples; cap_addr ends at 2.
  - done pulses once; wrap_cnt=0.
- Loop: length=3, loop_en=1 for 10 reads, then loop_en=0.
  - Address sequence 0,1,2,0,1,2,0,1,2,0,1,2 with no gaps.
  - wrap_cnt=3, then done.
  - Decimation counter not reset at wraps.
- Abort: stop asserted on the 4th RUN cycle of length=100.
  - Exactly 4 reads issued, 4 sample_valid, done 3 cycles after stop.
- Corner starts:
  - length=0 start: busy stays 0.
  - start and stop in the same cycle in IDLE: no playback.
  - start pulsed during RUN: no restart.
- Reset mid-RUN: RST pulsed at address 50. All outputs are 0 immediately and no done pulse occurs. A subsequent start replays from address 0 with cap_addr=0.
- Parameter sweep:
  - NUM_CH=4, SAMPLE_W=3, DECIM=1: sample_out matches packed RAM words bit-exactly, and cap_stb equals sample_valid.
  - wrap_cnt saturates at 255 with length=1 looping for 300 cycles.
